// File: rtl/encoder_pkg.sv
// Shared types and event_reg layout for the encoder event arbiter.
package encoder_pkg;

  typedef struct packed {
    logic       ovf;
    logic       clkwise;
    logic [3:0] id;
  } enc_event_t;

  localparam int EV_ID_LSB  = 0;
  localparam int EV_DIR_BIT = 4;
  localparam int EV_OVF_BIT = 5;

  // Queue entries carry only {clkwise, id}; overflow is overlaid live at the output.
  localparam int Q_W = 5;

  function automatic logic [7:0] pack_event_reg(input enc_event_t ev);
    logic [7:0] r;
    r = 8'h00;
    r[EV_ID_LSB +: 4] = ev.id;
    r[EV_DIR_BIT]     = ev.clkwise;
    r[EV_OVF_BIT]     = ev.ovf;
    return r;
  endfunction

endpackage

// File: rtl/encoder_event_fifo.sv
// Synchronous FIFO with a registered head stage; count includes the head entry.
module encoder_event_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [W-1:0]     head_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop_eff, push_eff, mem_has, load;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign pop_eff  = pop & valid_reg;
  assign push_eff = push & (~full | pop_eff);
  assign mem_has  = (wr_ptr_reg != rd_ptr_reg);
  // Head refills from storage when it is empty or being consumed this cycle.
  assign load     = mem_has & (~valid_reg | pop_eff);

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      head_reg   <= '0;
      valid_reg  <= 1'b0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (load) begin
        head_reg   <= mem[rd_ptr_reg[AW-1:0]];
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        valid_reg  <= 1'b1;
      end else if (pop_eff) begin
        valid_reg  <= 1'b0;
      end
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = head_reg;
  assign empty = ~valid_reg;
  assign count = count_reg;

endmodule

// File: rtl/encoder_event_arbiter.sv
// Latches per-channel encoder strobes, grants them round-robin into an event FIFO for the CPU.
module encoder_event_arbiter
  import encoder_pkg::*;
#(
  parameter int NUM_ENC    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_ENC-1:0] enc_event_stb,
  input  logic [NUM_ENC-1:0] enc_clkwise,
  input  logic               event_rd_stb,
  input  logic               overflow_clr_stb,
  output logic [7:0]         event_reg,
  output logic               event_valid,
  output logic [4:0]         event_count,
  output logic               irq
);

  localparam int ID_W  = $clog2(NUM_ENC);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_ENC-1:0] pending_reg, pending_next;
  logic [NUM_ENC-1:0] dir_reg, dir_next;
  logic [NUM_ENC-1:0] grant, ovf_hit;
  logic [ID_W-1:0]    rr_ptr_reg, grant_id;
  logic               grant_any, overflow_reg;

  logic               fifo_empty, fifo_full;
  logic [Q_W-1:0]     fifo_din, fifo_dout;
  logic [CNT_W-1:0]   fifo_count;
  enc_event_t         head_ev;

  // A re-strobe on the granted channel is a fresh event, not an overflow.
  for (genvar gi = 0; gi < NUM_ENC; gi++) begin : g_chan
    assign pending_next[gi] = enc_event_stb[gi] | (pending_reg[gi] & ~grant[gi]);
    assign dir_next[gi]     = enc_event_stb[gi] ? enc_clkwise[gi] : dir_reg[gi];
    assign ovf_hit[gi]      = enc_event_stb[gi] & pending_reg[gi] & ~grant[gi];
  end

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_ENC; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_ENC) idx = idx - NUM_ENC;
      if (!grant_any && !fifo_full && pending_reg[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  assign fifo_din = {dir_reg[grant_id], 4'(grant_id)};

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_reg  <= '0;
      dir_reg      <= '0;
      rr_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      dir_reg      <= dir_next;
      overflow_reg <= (|ovf_hit) | (overflow_reg & ~overflow_clr_stb);
      if (grant_any)
        rr_ptr_reg <= (grant_id == ID_W'(NUM_ENC - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  encoder_event_fifo #(
    .W     (Q_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (grant_any),
    .din   (fifo_din),
    .pop   (event_rd_stb),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_comb begin
    head_ev         = '0;
    head_ev.ovf     = overflow_reg;
    head_ev.clkwise = fifo_dout[4];
    head_ev.id      = fifo_dout[3:0];
  end

  assign event_valid = ~fifo_empty;
  assign irq         = ~fifo_empty;
  assign event_reg   = event_valid ? pack_event_reg(head_ev) : 8'h00;
  assign event_count = 5'(fifo_count);

endmodule
